// File: rtl/fp_sqrt_arb_pkg.sv
// Shared types and helpers for the fp_sqrt arbiter: FSM states, IEEE-754 single
// layout, canned NaN/inf encodings and the special-operand decoder.
package fp_sqrt_arb_pkg;

  localparam int unsigned EXP_W  = 8;
  localparam int unsigned FRAC_W = 23;
  localparam int unsigned FP_W   = 1 + EXP_W + FRAC_W;

  localparam logic [FP_W-1:0] FP_QNAN = 32'h7FC0_0000;
  localparam logic [FP_W-1:0] FP_PINF = 32'h7F80_0000;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2,
    RESP = 2'd3
  } state_e;

  typedef struct packed {
    logic              sign;
    logic [EXP_W-1:0]  exp;
    logic [FRAC_W-1:0] frac;
  } fp32_t;

  typedef struct packed {
    logic  bypass;
    fp32_t result;
  } special_t;

  // Operands whose square root is known without running the unit.
  // A negative denormal is treated as negative nonzero, so it yields NaN.
  function automatic special_t fp_special_decode(input fp32_t x);
    special_t r;
    r.bypass = 1'b1;
    r.result = '0;
    if (x.exp == '0 && x.frac == '0) begin
      r.result = {x.sign, 31'b0};
    end else if (x.exp == '1 && x.frac != '0) begin
      r.result = FP_QNAN;
    end else if (x.sign) begin
      r.result = FP_QNAN;
    end else if (x.exp == '1) begin
      r.result = FP_PINF;
    end else if (x.exp == '0) begin
      r.result = '0;
    end else begin
      r.bypass = 1'b0;
    end
    return r;
  endfunction

endpackage

// File: rtl/fp_sqrt_arbiter_rr.sv
// Combinational round-robin picker: first set request after ptr, wrapping.
module fp_rr_arbiter #(
  parameter int unsigned NREQ = 4
) (
  input  logic [NREQ-1:0]         req,
  input  logic [$clog2(NREQ)-1:0] ptr,
  output logic [NREQ-1:0]         grant_c,
  output logic [$clog2(NREQ)-1:0] idx_c,
  output logic                    any_c
);

  localparam int unsigned IDX_W = $clog2(NREQ);

  logic [IDX_W-1:0] cand;

  always_comb begin
    grant_c = '0;
    idx_c   = '0;
    any_c   = 1'b0;
    cand    = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      cand = IDX_W'((32'(ptr) + 32'd1 + i) % NREQ);
      if (!any_c && req[cand]) begin
        any_c       = 1'b1;
        grant_c[cand] = 1'b1;
        idx_c       = cand;
      end
    end
  end

endmodule

// File: rtl/fp_sqrt_arbiter.sv
// Shares one fp_sqrt unit between NREQ requesters, one operation at a time.
// Define FP_SQRT_ARB_SPECIAL_EN to answer special operands without the unit.
module fp_sqrt_arbiter #(
  parameter int unsigned NREQ        = 4,
  parameter int unsigned LOAD_CYCLES = 2,
  parameter int unsigned TIMEOUT     = 256
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [NREQ-1:0]  req_valid,
  output logic [NREQ-1:0]  req_ready,
  input  logic [NREQ*32-1:0] req_data,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [2:0]       rsp_id,
  output logic [31:0]      rsp_data,
  output logic             rsp_err,
  output logic             sq_reset,
  output logic             sq_sign,
  output logic [7:0]       sq_exp,
  output logic [22:0]      sq_frac,
  input  logic             sq_ready,
  input  logic             sq_o_sign,
  input  logic [7:0]       sq_o_exp,
  input  logic [22:0]      sq_o_frac
);

  import fp_sqrt_arb_pkg::*;

  localparam int unsigned IDX_W = $clog2(NREQ);
  localparam int unsigned LD_W  = $clog2(LOAD_CYCLES + 1);
  localparam int unsigned RUN_W = $clog2(TIMEOUT + 1);

  state_e           state_q, state_d;
  logic [IDX_W-1:0] ptr_q, ptr_d;
  logic [LD_W-1:0]  load_cnt_q, load_cnt_d;
  logic [RUN_W-1:0] run_cnt_q, run_cnt_d;
  logic             rsp_valid_q, rsp_valid_d;
  logic [2:0]       rsp_id_q, rsp_id_d;
  logic [31:0]      rsp_data_q, rsp_data_d;
  logic             rsp_err_q, rsp_err_d;
  logic             sq_reset_q, sq_reset_d;
  fp32_t            sq_op_q, sq_op_d;

  logic [NREQ-1:0]  grant;
  logic [IDX_W-1:0] gnt_idx;
  logic             gnt_any;
  logic [NREQ-1:0]  req_ready_c;
  logic [31:0]      req_word [NREQ];
`ifdef FP_SQRT_ARB_SPECIAL_EN
  special_t         spec;
`endif

  for (genvar g = 0; g < NREQ; g++) begin : g_unpack
    assign req_word[g] = req_data[32*g +: 32];
  end

  fp_rr_arbiter #(.NREQ(NREQ)) u_rr (
    .req     (req_valid),
    .ptr     (ptr_q),
    .grant_c (grant),
    .idx_c   (gnt_idx),
    .any_c   (gnt_any)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      ptr_q       <= IDX_W'(NREQ - 1);
      load_cnt_q  <= '0;
      run_cnt_q   <= '0;
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= '0;
      rsp_data_q  <= '0;
      rsp_err_q   <= 1'b0;
      sq_reset_q  <= 1'b1;
      sq_op_q     <= '0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      load_cnt_q  <= load_cnt_d;
      run_cnt_q   <= run_cnt_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_id_q    <= rsp_id_d;
      rsp_data_q  <= rsp_data_d;
      rsp_err_q   <= rsp_err_d;
      sq_reset_q  <= sq_reset_d;
      sq_op_q     <= sq_op_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    load_cnt_d  = load_cnt_q;
    run_cnt_d   = run_cnt_q;
    rsp_valid_d = rsp_valid_q;
    rsp_id_d    = rsp_id_q;
    rsp_data_d  = rsp_data_q;
    rsp_err_d   = rsp_err_q;
    sq_op_d     = sq_op_q;
    req_ready_c = '0;
`ifdef FP_SQRT_ARB_SPECIAL_EN
    spec        = fp_special_decode(req_word[gnt_idx]);
`endif

    case (state_q)
      IDLE: begin
        if (gnt_any) begin
          req_ready_c = grant;
          ptr_d       = gnt_idx;
          rsp_id_d    = 3'(gnt_idx);
`ifdef FP_SQRT_ARB_SPECIAL_EN
          if (spec.bypass) begin
            state_d     = RESP;
            rsp_valid_d = 1'b1;
            rsp_data_d  = spec.result;
            rsp_err_d   = 1'b0;
          end else begin
            state_d    = LOAD;
            sq_op_d    = req_word[gnt_idx];
            load_cnt_d = '0;
          end
`else
          state_d    = LOAD;
          sq_op_d    = req_word[gnt_idx];
          load_cnt_d = '0;
`endif
        end
      end
      LOAD: begin
        if (load_cnt_q == LD_W'(LOAD_CYCLES - 1)) begin
          state_d   = RUN;
          run_cnt_d = '0;
        end else begin
          load_cnt_d = load_cnt_q + LD_W'(1);
        end
      end
      RUN: begin
        run_cnt_d = run_cnt_q + RUN_W'(1);
        // The unit's done flag is still stale in the first RUN cycle.
        if (run_cnt_q != '0 && sq_ready) begin
          state_d     = RESP;
          rsp_valid_d = 1'b1;
          rsp_data_d  = {sq_o_sign, sq_o_exp, sq_o_frac};
          rsp_err_d   = 1'b0;
        end else if (run_cnt_q == RUN_W'(TIMEOUT - 1)) begin
          state_d     = RESP;
          rsp_valid_d = 1'b1;
          rsp_data_d  = FP_QNAN;
          rsp_err_d   = 1'b1;
        end
      end
      RESP: begin
        if (rsp_ready) begin
          state_d     = IDLE;
          rsp_valid_d = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase

    sq_reset_d = (state_d != RUN);
    if (reset) begin
      req_ready_c = '0;
    end
  end

  assign req_ready = req_ready_c;
  assign rsp_valid = rsp_valid_q;
  assign rsp_id    = rsp_id_q;
  assign rsp_data  = rsp_data_q;
  assign rsp_err   = rsp_err_q;
  assign sq_reset  = sq_reset_q;
  assign sq_sign   = sq_op_q.sign;
  assign sq_exp    = sq_op_q.exp;
  assign sq_frac   = sq_op_q.frac;

endmodule

// File: tb/tb_fp_sqrt_arbiter.sv
// Directed bench for fp_sqrt_arbiter with a behavioural fp_sqrt unit model.
module tb_fp_sqrt_arbiter;

  localparam int unsigned NREQ        = 4;
  localparam int unsigned LOAD_CYCLES = 2;
  localparam int unsigned TIMEOUT     = 256;
  localparam int unsigned UNIT_LAT    = 3;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic [NREQ-1:0]   req_valid = '0;
  logic [NREQ-1:0]   req_ready;
  logic [31:0]       req_word [NREQ];
  logic [NREQ*32-1:0] req_data;
  logic              rsp_valid;
  logic              rsp_ready = 1'b0;
  logic [2:0]        rsp_id;
  logic [31:0]       rsp_data;
  logic              rsp_err;
  logic              sq_reset, sq_sign;
  logic [7:0]        sq_exp;
  logic [22:0]       sq_frac;
  logic              sq_ready = 1'b0;
  logic              sq_o_sign;
  logic [7:0]        sq_o_exp;
  logic [22:0]       sq_o_frac;

  logic              stale_en = 1'b1;
  logic              hang = 1'b0;
  int unsigned       m_cnt = 0;
  logic [31:0]       o_data = 32'h0;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  assign req_data = {req_word[3], req_word[2], req_word[1], req_word[0]};
  assign {sq_o_sign, sq_o_exp, sq_o_frac} = o_data;

  fp_sqrt_arbiter #(.NREQ(NREQ), .LOAD_CYCLES(LOAD_CYCLES), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_data(req_data),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_data(rsp_data), .rsp_err(rsp_err),
    .sq_reset(sq_reset), .sq_sign(sq_sign), .sq_exp(sq_exp), .sq_frac(sq_frac),
    .sq_ready(sq_ready), .sq_o_sign(sq_o_sign), .sq_o_exp(sq_o_exp), .sq_o_frac(sq_o_frac)
  );

  function automatic logic [31:0] sqrt_ref(input logic [31:0] x);
    case (x)
      32'h41440000: return 32'h40600000;
      32'h41C80000: return 32'h40A00000;
      32'h40800000: return 32'h40000000;
      32'h41100000: return 32'h40400000;
      32'h41800000: return 32'h40800000;
      default:      return 32'h7FC00000;
    endcase
  endfunction

  // Unit model: done flag keeps its held-in-reset value for the first run cycle.
  always @(posedge clk) begin
    if (sq_reset === 1'b1) begin
      m_cnt    <= 0;
      sq_ready <= stale_en;
      o_data   <= 32'hDEADBEEF;
    end else begin
      m_cnt    <= m_cnt + 1;
      sq_ready <= !hang && (m_cnt + 1 >= UNIT_LAT);
      o_data   <= sqrt_ref({sq_sign, sq_exp, sq_frac});
    end
  end

  initial begin
    #1000000;
    $display("FAIL global_timeout simulation did not finish");
    $fatal(1, "global timeout");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Advance from the grant cycle to the first cycle with rsp_valid (or bound).
  task automatic wait_rsp(input int bound, input bit drop,
                          output int lat, output int load_n, output int rr_pulses);
    bit in_run;
    in_run = 1'b0;
    lat = 0; load_n = 0; rr_pulses = 0;
    while (rsp_valid !== 1'b1 && lat < bound) begin
      tick();
      if (drop && lat == 0) req_valid = '0;
      lat++;
      if (!in_run) begin
        if (sq_reset === 1'b1) load_n++;
        else in_run = 1'b1;
      end
      if (req_ready !== '0) rr_pulses++;
    end
  endtask

  task automatic test_reset();
    for (int i = 0; i < NREQ; i++) req_word[i] = 32'h3F800000;
    reset = 1'b1;
    req_valid = 4'b1111;
    tick(); tick();
    n_cmp++; if (req_ready !== 4'b0000) begin n_err++; $display("FAIL reset_req_ready got=%b exp=0000", req_ready); end
    n_cmp++; if (rsp_valid !== 1'b0) begin n_err++; $display("FAIL reset_rsp_valid got=%b exp=0", rsp_valid); end
    n_cmp++; if ({rsp_id, rsp_data, rsp_err} !== 36'h0) begin n_err++; $display("FAIL reset_rsp got id=%h data=%h err=%b exp=0", rsp_id, rsp_data, rsp_err); end
    n_cmp++; if (sq_reset !== 1'b1) begin n_err++; $display("FAIL reset_sq_reset got=%b exp=1", sq_reset); end
    n_cmp++; if ({sq_sign, sq_exp, sq_frac} !== 32'h0) begin n_err++; $display("FAIL reset_sq_op got=%h exp=0", {sq_sign, sq_exp, sq_frac}); end
    reset = 1'b0;
    req_valid = '0;
    tick();
  endtask

  task automatic test_single();
    int lat, load_n, pulses;
    req_word[0] = 32'h41440000;
    req_valid = 4'b0001;
    #1;
    n_cmp++; if (req_ready !== 4'b0001) begin n_err++; $display("FAIL single_grant got=%b exp=0001", req_ready); end
    wait_rsp(400, 1'b1, lat, load_n, pulses);
    n_cmp++; if (load_n !== LOAD_CYCLES) begin n_err++; $display("FAIL single_load_cycles got=%0d exp=%0d", load_n, LOAD_CYCLES); end
    n_cmp++; if (lat !== LOAD_CYCLES + UNIT_LAT + 2) begin n_err++; $display("FAIL single_latency got=%0d exp=%0d", lat, LOAD_CYCLES + UNIT_LAT + 2); end
    n_cmp++; if (rsp_data !== 32'h40600000) begin n_err++; $display("FAIL single_data got=%h exp=40600000", rsp_data); end
    n_cmp++; if (rsp_id !== 3'd0 || rsp_err !== 1'b0) begin n_err++; $display("FAIL single_id_err got id=%0d err=%b exp id=0 err=0", rsp_id, rsp_err); end
    rsp_ready = 1'b1; tick(); rsp_ready = 1'b0;
    n_cmp++; if (rsp_valid !== 1'b0) begin n_err++; $display("FAIL single_rsp_drop got=%b exp=0", rsp_valid); end
  endtask

  task automatic test_round_robin();
    int lat, load_n, pulses;
    logic [31:0] rr_in [4];
    logic [31:0] rr_out [4];
    logic [1:0] g;
    rr_in  = '{32'h41C80000, 32'h40800000, 32'h41100000, 32'h41800000};
    rr_out = '{32'h40A00000, 32'h40000000, 32'h40400000, 32'h40800000};
    for (int i = 0; i < NREQ; i++) req_word[i] = rr_in[i];
    reset = 1'b1; tick(); tick();
    reset = 1'b0;
    req_valid = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      g = 2'(k);
      #1;
      n_cmp++; if (req_ready !== (4'b0001 << g)) begin n_err++; $display("FAIL rr_grant%0d got=%b exp=%b", k, req_ready, 4'b0001 << g); end
      wait_rsp(400, 1'b0, lat, load_n, pulses);
      n_cmp++; if (rsp_id !== 3'(g) || rsp_data !== rr_out[g]) begin n_err++; $display("FAIL rr_rsp%0d got id=%0d data=%h exp id=%0d data=%h", k, rsp_id, rsp_data, g, rr_out[g]); end
      n_cmp++; if (pulses !== 0) begin n_err++; $display("FAIL rr_busy_grant%0d got=%0d exp=0", k, pulses); end
      rsp_ready = 1'b1; tick(); rsp_ready = 1'b0;
    end
    req_valid = '0;
    tick();
  endtask

  task automatic test_backpressure();
    int lat, load_n, pulses, bad;
    req_valid = 4'b1111;
    #1;
    n_cmp++; if (req_ready !== 4'b0010) begin n_err++; $display("FAIL bp_grant got=%b exp=0010", req_ready); end
    wait_rsp(400, 1'b0, lat, load_n, pulses);
    n_cmp++; if (rsp_valid !== 1'b1 || rsp_data !== 32'h40000000) begin n_err++; $display("FAIL bp_rsp got valid=%b data=%h exp 1/40000000", rsp_valid, rsp_data); end
    bad = 0;
    repeat (10) begin
      tick();
      if (rsp_valid !== 1'b1 || rsp_data !== 32'h40000000 || rsp_id !== 3'd1 || rsp_err !== 1'b0 ||
          req_ready !== 4'b0000 || sq_reset !== 1'b1) bad++;
    end
    n_cmp++; if (bad !== 0) begin n_err++; $display("FAIL bp_hold unstable_cycles=%0d exp=0", bad); end
    req_valid = '0;
    rsp_ready = 1'b1; tick(); rsp_ready = 1'b0;
    n_cmp++; if (rsp_valid !== 1'b0) begin n_err++; $display("FAIL bp_release got=%b exp=0", rsp_valid); end
  endtask

  task automatic test_timeout();
    int lat, load_n, pulses;
    hang = 1'b1;
    req_valid = 4'b0001;
    #1;
    n_cmp++; if (req_ready !== 4'b0001) begin n_err++; $display("FAIL to_grant got=%b exp=0001", req_ready); end
    wait_rsp(400, 1'b1, lat, load_n, pulses);
    n_cmp++; if (lat !== LOAD_CYCLES + TIMEOUT + 1) begin n_err++; $display("FAIL to_latency got=%0d exp=%0d", lat, LOAD_CYCLES + TIMEOUT + 1); end
    n_cmp++; if (rsp_data !== 32'h7FC00000 || rsp_err !== 1'b1 || rsp_id !== 3'd0) begin n_err++; $display("FAIL to_rsp got data=%h err=%b id=%0d exp 7fc00000/1/0", rsp_data, rsp_err, rsp_id); end
    rsp_ready = 1'b1; tick(); rsp_ready = 1'b0;
    hang = 1'b0;
  endtask

  task automatic test_reset_mid_run();
    int lat, load_n, pulses, n, seen;
    req_valid = 4'b0100;
    #1;
    n_cmp++; if (req_ready !== 4'b0100) begin n_err++; $display("FAIL mid_grant got=%b exp=0100", req_ready); end
    tick();
    req_valid = '0;
    n = 0;
    while (sq_reset !== 1'b0 && n < 20) begin tick(); n++; end
    n_cmp++; if (sq_reset !== 1'b0) begin n_err++; $display("FAIL mid_run_entry got sq_reset=%b exp=0", sq_reset); end
    tick();
    reset = 1'b1; tick(); reset = 1'b0;
    n_cmp++; if (sq_reset !== 1'b1 || rsp_valid !== 1'b0) begin n_err++; $display("FAIL mid_abort got sq_reset=%b rsp_valid=%b exp 1/0", sq_reset, rsp_valid); end
    seen = 0;
    repeat (12) begin tick(); if (rsp_valid !== 1'b0) seen++; end
    n_cmp++; if (seen !== 0) begin n_err++; $display("FAIL mid_no_rsp got=%0d exp=0", seen); end
    req_valid = 4'b1111;
    #1;
    n_cmp++; if (req_ready !== 4'b0001) begin n_err++; $display("FAIL mid_regrant got=%b exp=0001", req_ready); end
    wait_rsp(400, 1'b1, lat, load_n, pulses);
    n_cmp++; if (rsp_data !== 32'h40A00000 || rsp_id !== 3'd0) begin n_err++; $display("FAIL mid_rsp got data=%h id=%0d exp 40a00000/0", rsp_data, rsp_id); end
    rsp_ready = 1'b1; tick(); rsp_ready = 1'b0;
  endtask

  task automatic test_special();
    int lat, load_n, pulses;
`ifdef FP_SQRT_ARB_SPECIAL_EN
    logic [31:0] sp_in [4];
    logic [31:0] sp_out [4];
    logic [1:0] g;
    sp_in  = '{32'hC0800000, 32'h7F800000, 32'h80000000, 32'h00000001};
    sp_out = '{32'h7FC00000, 32'h7F800000, 32'h80000000, 32'h00000000};
    for (int k = 0; k < 4; k++) begin
      g = 2'(k + 1);
      req_word[g] = sp_in[k];
      req_valid = 4'b0001 << g;
      #1;
      n_cmp++; if (req_ready !== (4'b0001 << g)) begin n_err++; $display("FAIL sp_grant%0d got=%b exp=%b", k, req_ready, 4'b0001 << g); end
      wait_rsp(400, 1'b1, lat, load_n, pulses);
      n_cmp++; if (lat !== 1 || load_n !== 1) begin n_err++; $display("FAIL sp_bypass%0d got lat=%0d sq_reset_hi=%0d exp 1/1", k, lat, load_n); end
      n_cmp++; if (rsp_data !== sp_out[k] || rsp_err !== 1'b0 || rsp_id !== 3'(g)) begin n_err++; $display("FAIL sp_rsp%0d got data=%h err=%b id=%0d exp %h/0/%0d", k, rsp_data, rsp_err, rsp_id, sp_out[k], g); end
      n_cmp++; if ({sq_sign, sq_exp, sq_frac} !== 32'h41C80000) begin n_err++; $display("FAIL sp_unit_touched%0d got=%h exp=41c80000", k, {sq_sign, sq_exp, sq_frac}); end
      rsp_ready = 1'b1; tick(); rsp_ready = 1'b0;
    end
`else
    req_word[1] = 32'hC0800000;
    req_valid = 4'b0010;
    #1;
    n_cmp++; if (req_ready !== 4'b0010) begin n_err++; $display("FAIL neg_grant got=%b exp=0010", req_ready); end
    wait_rsp(400, 1'b1, lat, load_n, pulses);
    n_cmp++; if (lat !== LOAD_CYCLES + UNIT_LAT + 2 || load_n !== LOAD_CYCLES) begin n_err++; $display("FAIL neg_unit_run got lat=%0d load=%0d exp %0d/%0d", lat, load_n, LOAD_CYCLES + UNIT_LAT + 2, LOAD_CYCLES); end
    n_cmp++; if (rsp_data !== 32'h7FC00000 || rsp_err !== 1'b0 || rsp_id !== 3'd1) begin n_err++; $display("FAIL neg_rsp got data=%h err=%b id=%0d exp 7fc00000/0/1", rsp_data, rsp_err, rsp_id); end
    n_cmp++; if ({sq_sign, sq_exp, sq_frac} !== 32'hC0800000) begin n_err++; $display("FAIL neg_operand got=%h exp=c0800000", {sq_sign, sq_exp, sq_frac}); end
    rsp_ready = 1'b1; tick(); rsp_ready = 1'b0;
`endif
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_backpressure();
    test_timeout();
    test_reset_mid_run();
    test_special();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
